// File: rtl/async_fifo_fwft_if.sv
// Producer/consumer bundle for async_fifo_fwft. The FIFO connects through the slave
// modport and the surrounding logic connects through the master modport.
interface async_fifo_fwft_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             full;
    logic             almost_full;
    logic [LVL_W-1:0] wr_level;
    logic             overflow;

    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             empty;
    logic             almost_empty;
    logic [LVL_W-1:0] rd_level;
    logic             underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  full, almost_full, wr_level, overflow,
        input  rd_data, rd_valid, empty, almost_empty, rd_level, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output full, almost_full, wr_level, overflow,
        output rd_data, rd_valid, empty, almost_empty, rd_level, underflow
    );
endinterface

// File: rtl/async_fifo_fwft.sv
// Dual-clock Gray-pointer FIFO with an optional first-word-fall-through output register,
// occupancy levels and almost/sticky-error flags on both sides.
module async_fifo_fwft #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int FWFT          = 1,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input logic              rd_clk,
    input logic              wr_clk,
    input logic              reset,
    async_fifo_fwft_if.slave bus
);
    localparam int ADDR = $clog2(DEPTH);
    localparam int PW   = ADDR + 1;
    localparam logic [PW-1:0] AFULL_LVL  = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AEMPTY_LVL = PW'(AEMPTY_THRESH);
    localparam logic FWFT_MODE = (FWFT != 0);

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];

    // ---------------- write domain ----------------
    logic [PW-1:0]                  wr_bin;
    logic [PW-1:0]                  wr_gray;
    logic [PW-1:0]                  wr_bin_next;
    logic [PW-1:0]                  wr_gray_next;
    logic [SYNC_STAGES-1:0][PW-1:0] rd_gray_chain;
    logic [PW-1:0]                  rd_gray_sync;
    logic [PW-1:0]                  wr_level_w;
    logic                           wr_accept;
    logic                           full_q;
    logic                           overflow_q;

    assign wr_accept    = bus.wr_en && !full_q;
    assign wr_bin_next  = wr_bin + {{ADDR{1'b0}}, wr_accept};
    assign wr_gray_next = bin2gray(wr_bin_next);
    assign rd_gray_sync = rd_gray_chain[SYNC_STAGES-1];
    assign wr_level_w   = wr_bin - gray2bin(rd_gray_sync);

    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            wr_bin        <= '0;
            wr_gray       <= '0;
            full_q        <= 1'b0;
            overflow_q    <= 1'b0;
            rd_gray_chain <= '0;
        end else begin
            wr_bin        <= wr_bin_next;
            wr_gray       <= wr_gray_next;
            // Full when the write pointer has lapped the read pointer exactly once.
            full_q        <= (wr_gray_next ==
                              {~rd_gray_sync[PW-1:PW-2], rd_gray_sync[PW-3:0]});
            overflow_q    <= overflow_q | (bus.wr_en && full_q);
            rd_gray_chain <= {rd_gray_chain[SYNC_STAGES-2:0], rd_gray};
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_accept) begin
            mem[wr_bin[ADDR-1:0]] <= bus.wr_data;
        end
    end

    assign bus.full        = full_q;
    assign bus.almost_full = (wr_level_w >= AFULL_LVL);
    assign bus.wr_level    = wr_level_w;
    assign bus.overflow    = overflow_q;

    // ---------------- read domain ----------------
    // fetch_bin addresses memory; pop_bin counts words handed to the consumer and is
    // the pointer that frees slots, so the output register never adds hidden capacity.
    logic [PW-1:0]                  fetch_bin;
    logic [PW-1:0]                  fetch_bin_next;
    logic [PW-1:0]                  pop_bin;
    logic [PW-1:0]                  pop_bin_next;
    logic [PW-1:0]                  rd_gray;
    logic [SYNC_STAGES-1:0][PW-1:0] wr_gray_chain;
    logic [PW-1:0]                  wr_gray_sync;
    logic [PW-1:0]                  rd_level_w;
    logic                           mem_empty;
    logic                           out_valid;
    logic [WIDTH-1:0]               out_data;
    logic                           fetch;
    logic                           pop;
    logic                           rd_empty;
    logic                           underflow_q;

    assign wr_gray_sync = wr_gray_chain[SYNC_STAGES-1];

    always_comb begin
        fetch = 1'b0;
        pop   = 1'b0;
        if (FWFT_MODE) begin
            pop   = bus.rd_en && out_valid;
            fetch = !mem_empty && (!out_valid || pop);
        end else begin
            fetch = bus.rd_en && !mem_empty;
            pop   = fetch;
        end
    end

    assign rd_empty       = FWFT_MODE ? !out_valid : mem_empty;
    assign fetch_bin_next = fetch_bin + {{ADDR{1'b0}}, fetch};
    assign pop_bin_next   = pop_bin + {{ADDR{1'b0}}, pop};
    assign rd_level_w     = gray2bin(wr_gray_sync) - pop_bin;

    always_ff @(posedge rd_clk or posedge reset) begin
        if (reset) begin
            fetch_bin     <= '0;
            pop_bin       <= '0;
            rd_gray       <= '0;
            mem_empty     <= 1'b1;
            out_valid     <= 1'b0;
            out_data      <= '0;
            underflow_q   <= 1'b0;
            wr_gray_chain <= '0;
        end else begin
            fetch_bin     <= fetch_bin_next;
            pop_bin       <= pop_bin_next;
            rd_gray       <= bin2gray(pop_bin_next);
            mem_empty     <= (bin2gray(fetch_bin_next) == wr_gray_sync);
            // FWFT holds the word until popped; standard mode pulses valid per read.
            out_valid     <= fetch || (FWFT_MODE && out_valid && !pop);
            if (fetch) begin
                out_data <= mem[fetch_bin[ADDR-1:0]];
            end
            underflow_q   <= underflow_q | (bus.rd_en && rd_empty);
            wr_gray_chain <= {wr_gray_chain[SYNC_STAGES-2:0], wr_gray};
        end
    end

    assign bus.rd_data      = out_data;
    assign bus.rd_valid     = out_valid;
    assign bus.empty        = rd_empty;
    assign bus.almost_empty = (rd_level_w <= AEMPTY_LVL);
    assign bus.rd_level     = rd_level_w;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_async_fifo_fwft.sv
// Bench for async_fifo_fwft: one FWFT and one standard-mode instance sharing clocks,
// directed corner sequences plus a queued-expectation random stream at two clock ratios.
`timescale 1ns/1ps
module tb_async_fifo_fwft;
    localparam int W      = 8;
    localparam int D      = 16;
    localparam int SS     = 2;
    localparam int NWORDS = 1040;
    localparam int LIMIT  = 12000;

    typedef struct {
        logic [7:0] data;
        logic       accept;
        logic       exp_full;
        logic       exp_afull;
        logic       exp_ovf;
        logic [4:0] exp_level;
    } vec_t;

    logic    wr_clk = 1'b0;
    logic    rd_clk = 1'b0;
    logic    reset  = 1'b1;
    realtime wr_half = 5.0;
    realtime rd_half = 13.5;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] q_f[$];
    logic [7:0] q_s[$];
    vec_t       tbl[16];
    logic       found;
    logic [7:0] exp_b;

    async_fifo_fwft_if #(.WIDTH(W), .DEPTH(D)) bus_f ();
    async_fifo_fwft_if #(.WIDTH(W), .DEPTH(D)) bus_s ();

    async_fifo_fwft #(.WIDTH(W), .DEPTH(D), .SYNC_STAGES(SS), .FWFT(1),
                      .AFULL_THRESH(14), .AEMPTY_THRESH(2)) u_fwft (
        .rd_clk(rd_clk), .wr_clk(wr_clk), .reset(reset), .bus(bus_f));

    async_fifo_fwft #(.WIDTH(W), .DEPTH(D), .SYNC_STAGES(SS), .FWFT(0),
                      .AFULL_THRESH(14), .AEMPTY_THRESH(2)) u_std (
        .rd_clk(rd_clk), .wr_clk(wr_clk), .reset(reset), .bus(bus_s));

    always #(wr_half) wr_clk = ~wr_clk;
    always #(rd_half) rd_clk = ~rd_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_f_empty"}, bus_f.empty, 1);
        check({tag, "_f_aempty"}, bus_f.almost_empty, 1);
        check({tag, "_f_full"}, bus_f.full, 0);
        check({tag, "_f_afull"}, bus_f.almost_full, 0);
        check({tag, "_f_valid"}, bus_f.rd_valid, 0);
        check({tag, "_f_data"}, bus_f.rd_data, 0);
        check({tag, "_f_wlvl"}, bus_f.wr_level, 0);
        check({tag, "_f_rlvl"}, bus_f.rd_level, 0);
        check({tag, "_f_ovf"}, bus_f.overflow, 0);
        check({tag, "_f_unf"}, bus_f.underflow, 0);
        check({tag, "_s_empty"}, bus_s.empty, 1);
        check({tag, "_s_full"}, bus_s.full, 0);
        check({tag, "_s_valid"}, bus_s.rd_valid, 0);
        check({tag, "_s_data"}, bus_s.rd_data, 0);
        check({tag, "_s_ovf"}, bus_s.overflow, 0);
        check({tag, "_s_unf"}, bus_s.underflow, 0);
    endtask

    task automatic stream_writer();
        int acc_f = 0;
        int acc_s = 0;
        int cyc   = 0;
        while ((acc_f < NWORDS || acc_s < NWORDS) && cyc < LIMIT) begin
            @(negedge wr_clk);
            cyc++;
            bus_f.wr_en = 1'b0;
            bus_s.wr_en = 1'b0;
            if (acc_f < NWORDS && !bus_f.full && $urandom_range(99) < 60) begin
                bus_f.wr_en   = 1'b1;
                bus_f.wr_data = 8'($urandom);
                q_f.push_back(bus_f.wr_data);
                acc_f++;
            end
            if (acc_s < NWORDS && !bus_s.full && $urandom_range(99) < 60) begin
                bus_s.wr_en   = 1'b1;
                bus_s.wr_data = 8'($urandom);
                q_s.push_back(bus_s.wr_data);
                acc_s++;
            end
        end
        @(negedge wr_clk);
        bus_f.wr_en = 1'b0;
        bus_s.wr_en = 1'b0;
        check("stream_writes_f", acc_f, NWORDS);
        check("stream_writes_s", acc_s, NWORDS);
    endtask

    task automatic stream_reader_f();
        int got = 0;
        int cyc = 0;
        while (got < NWORDS && cyc < LIMIT) begin
            @(negedge rd_clk);
            cyc++;
            bus_f.rd_en = 1'b0;
            if (!bus_f.empty && $urandom_range(99) < 60) begin
                bus_f.rd_en = 1'b1;
                if (q_f.size() == 0) check("stream_f_extra_word", bus_f.rd_data, 'hx);
                else check("stream_f_data", bus_f.rd_data, q_f.pop_front());
                got++;
            end
        end
        @(negedge rd_clk);
        bus_f.rd_en = 1'b0;
        check("stream_f_count", got, NWORDS);
    endtask

    task automatic stream_reader_s();
        int got = 0;
        int cyc = 0;
        while (got < NWORDS && cyc < LIMIT) begin
            @(negedge rd_clk);
            cyc++;
            if (bus_s.rd_valid) begin
                if (q_s.size() == 0) check("stream_s_extra_word", bus_s.rd_data, 'hx);
                else check("stream_s_data", bus_s.rd_data, q_s.pop_front());
                got++;
            end
            bus_s.rd_en = (got < NWORDS) && !bus_s.empty && ($urandom_range(99) < 60);
        end
        bus_s.rd_en = 1'b0;
        check("stream_s_count", got, NWORDS);
    endtask

    task automatic run_stream(input realtime wh, input realtime rh, input string tag);
        wr_half = wh;
        rd_half = rh;
        repeat (4) @(negedge rd_clk);
        fork
            stream_writer();
            stream_reader_f();
            stream_reader_s();
        join
        repeat (SS + 4) @(negedge wr_clk);
        repeat (SS + 4) @(negedge rd_clk);
        check({tag, "_f_empty"}, bus_f.empty, 1);
        check({tag, "_f_full"}, bus_f.full, 0);
        check({tag, "_f_levels"}, {bus_f.wr_level, bus_f.rd_level}, 0);
        check({tag, "_f_errflags"}, {bus_f.overflow, bus_f.underflow}, 0);
        check({tag, "_s_empty"}, bus_s.empty, 1);
        check({tag, "_s_full"}, bus_s.full, 0);
        check({tag, "_s_levels"}, {bus_s.wr_level, bus_s.rd_level}, 0);
        check({tag, "_s_errflags"}, {bus_s.overflow, bus_s.underflow}, 0);
        check({tag, "_leftover"}, q_f.size() + q_s.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 15; i++) begin
            tbl[i] = '{data: 8'(i + 2), accept: 1'b1, exp_full: (i + 2 == 16),
                       exp_afull: (i + 2 >= 14), exp_ovf: 1'b0, exp_level: 5'(i + 2)};
        end
        tbl[15] = '{data: 8'hAA, accept: 1'b0, exp_full: 1'b1, exp_afull: 1'b1,
                    exp_ovf: 1'b1, exp_level: 5'd16};

        bus_f.wr_en = 0; bus_f.wr_data = 0; bus_f.rd_en = 0;
        bus_s.wr_en = 0; bus_s.wr_data = 0; bus_s.rd_en = 0;
        #35;
        check_reset("in_reset");
        @(negedge wr_clk);
        reset = 1'b0;
        repeat (4) @(negedge rd_clk);
        check_reset("idle");

        // First word falls through to the FWFT output within the crossing bound.
        @(negedge wr_clk);
        bus_f.wr_en = 1'b1; bus_f.wr_data = 8'h01; q_f.push_back(8'h01);
        @(posedge wr_clk); #1; bus_f.wr_en = 1'b0;
        found = 1'b0;
        for (int k = 0; k < SS + 3 && !found; k++) begin
            @(posedge rd_clk); #1; found = bus_f.rd_valid;
        end
        check("first_word_latency", found, 1);
        check("first_word_data", bus_f.rd_data, 8'h01);

        // Fill to full and attempt one more write.
        for (int i = 0; i < 16; i++) begin
            @(negedge wr_clk);
            bus_f.wr_en = 1'b1; bus_f.wr_data = tbl[i].data;
            if (tbl[i].accept) q_f.push_back(tbl[i].data);
            @(negedge wr_clk);
            bus_f.wr_en = 1'b0;
            check($sformatf("fill%0d_full", i), bus_f.full, tbl[i].exp_full);
            check($sformatf("fill%0d_afull", i), bus_f.almost_full, tbl[i].exp_afull);
            check($sformatf("fill%0d_ovf", i), bus_f.overflow, tbl[i].exp_ovf);
            check($sformatf("fill%0d_wlvl", i), bus_f.wr_level, tbl[i].exp_level);
        end

        // Back-to-back drain, then one read on empty.
        repeat (SS + 3) @(posedge rd_clk);
        @(negedge rd_clk);
        check("pre_drain_rlvl", bus_f.rd_level, 16);
        check("pre_drain_full", bus_f.full, 1);
        bus_f.rd_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check("drain_valid", bus_f.rd_valid, 1);
            exp_b = q_f.pop_front();
            check($sformatf("drain%0d_data", k), bus_f.rd_data, exp_b);
            check($sformatf("drain%0d_rlvl", k), bus_f.rd_level, 16 - k);
            check($sformatf("drain%0d_aempty", k), bus_f.almost_empty, (16 - k) <= 2);
            @(negedge rd_clk);
        end
        check("drained_empty", bus_f.empty, 1);
        check("drained_valid", bus_f.rd_valid, 0);
        check("drained_rlvl", bus_f.rd_level, 0);
        check("drained_unf_clear", bus_f.underflow, 0);
        @(negedge rd_clk);
        bus_f.rd_en = 1'b0;
        check("underflow_set", bus_f.underflow, 1);
        check("underflow_no_word", bus_f.rd_valid, 0);

        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge wr_clk); found = !bus_f.full;
        end
        check("full_release", found, 1);
        repeat (SS + 3) @(negedge wr_clk);
        check("released_wlvl", bus_f.wr_level, 0);
        check("released_afull", bus_f.almost_full, 0);
        check("overflow_sticky", bus_f.overflow, 1);

        // Standard mode: one-cycle valid pulse, data hold, underflow.
        @(negedge wr_clk);
        bus_s.wr_en = 1'b1; bus_s.wr_data = 8'h3C;
        @(posedge wr_clk); #1; bus_s.wr_en = 1'b0;
        found = 1'b0;
        for (int k = 0; k < SS + 3 && !found; k++) begin
            @(posedge rd_clk); #1; found = !bus_s.empty;
        end
        check("std_latency", found, 1);
        check("std_valid_idle", bus_s.rd_valid, 0);
        @(negedge rd_clk); bus_s.rd_en = 1'b1;
        @(negedge rd_clk); bus_s.rd_en = 1'b0;
        check("std_valid_pulse", bus_s.rd_valid, 1);
        check("std_data", bus_s.rd_data, 8'h3C);
        check("std_empty_after", bus_s.empty, 1);
        @(negedge rd_clk);
        check("std_valid_drop", bus_s.rd_valid, 0);
        check("std_data_hold", bus_s.rd_data, 8'h3C);
        check("std_unf_clear", bus_s.underflow, 0);
        bus_s.rd_en = 1'b1;
        @(negedge rd_clk); bus_s.rd_en = 1'b0;
        check("std_unf_set", bus_s.underflow, 1);
        check("std_unf_no_word", bus_s.rd_valid, 0);

        // Reset mid-stream with nine words buffered.
        for (int i = 0; i < 9; i++) begin
            @(negedge wr_clk);
            bus_f.wr_en = 1'b1; bus_f.wr_data = 8'(8'h20 + i); q_f.push_back(bus_f.wr_data);
        end
        @(negedge wr_clk); bus_f.wr_en = 1'b0;
        repeat (SS + 4) @(posedge rd_clk);
        @(negedge rd_clk);
        check("pre_reset_rlvl", bus_f.rd_level, 9);
        check("pre_reset_valid", bus_f.rd_valid, 1);
        #3; reset = 1'b1; #1;
        check_reset("mid_reset");
        q_f.delete();
        #40;
        @(negedge wr_clk); reset = 1'b0;
        @(negedge wr_clk);
        bus_f.wr_en = 1'b1; bus_f.wr_data = 8'h55; q_f.push_back(8'h55);
        @(posedge wr_clk); #1; bus_f.wr_en = 1'b0;
        found = 1'b0;
        for (int k = 0; k < SS + 3 && !found; k++) begin
            @(posedge rd_clk); #1; found = bus_f.rd_valid;
        end
        check("post_reset_latency", found, 1);
        @(negedge rd_clk);
        exp_b = q_f.pop_front();
        check("post_reset_first_word", bus_f.rd_data, exp_b);
        bus_f.rd_en = 1'b1;
        @(negedge rd_clk); bus_f.rd_en = 1'b0;
        repeat (8) @(negedge rd_clk);
        check("no_stale_empty", bus_f.empty, 1);
        check("no_stale_valid", bus_f.rd_valid, 0);
        check("no_stale_rlvl", bus_f.rd_level, 0);

        run_stream(5.0, 15.0, "wr_fast");
        run_stream(15.0, 5.0, "rd_fast");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
